// File: rtl/sms_pkg.sv
// Shared definitions for the NVRAM save/load sequencer.
// It holds the SD sector size and the sequencer state encoding.
package sms_pkg;

    localparam int SD_SECTOR_BYTES = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } sms_state_e;

endpackage

// File: rtl/nvram_backup_ctrl.sv
// Battery-backup save/load sequencer: issues one SD sector request per NVRAM
// sector, tracks whether NVRAM changed since the last transfer, and arms on image mount.
module nvram_backup_ctrl
    import sms_pkg::*;
#(
    parameter int SECT_BITS = 6,
    parameter int SLOT_BITS = 2
) (
    input  logic                 clk_sys,
    input  logic                 RESET_n,
    input  logic                 download,
    input  logic                 img_mounted,
    input  logic [31:0]          img_size,
    input  logic                 bk_load,
    input  logic                 bk_save,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 nvram_we,
    input  logic                 sd_ack,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic                 bk_ena,
    output logic                 busy,
    output logic                 loading,
    output logic                 dirty,
    output logic                 done
);

    localparam int LBA_BITS = SLOT_BITS + SECT_BITS;

    sms_state_e           state_reg, state_next;
    logic [SECT_BITS-1:0] index_reg, index_next;
    logic [SLOT_BITS-1:0] slot_reg, slot_next;
    logic                 loading_reg, loading_next;
    logic                 dirty_reg, dirty_next;
    logic                 done_reg, done_next;
    logic                 bk_ena_reg, bk_ena_next;
    logic                 dl_q, ld_q, sv_q, ack_q;

    logic dl_rise, ld_trig, sv_trig, ack_rise, ack_fall, busy_int;

    assign dl_rise  = download & ~dl_q;
    assign ld_trig  = bk_load & bk_ena_reg & ~ld_q;
    assign sv_trig  = bk_save & bk_ena_reg & ~sv_q;
    assign ack_rise = sd_ack & ~ack_q;
    assign ack_fall = ~sd_ack & ack_q;
    assign busy_int = (state_reg != IDLE);

    // Edge-detect history; the trigger registers are gated by bk_ena so a
    // request held high across arming still produces a fresh edge.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            dl_q  <= 1'b0;
            ld_q  <= 1'b0;
            sv_q  <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            dl_q  <= download;
            ld_q  <= bk_load & bk_ena_reg;
            sv_q  <= bk_save & bk_ena_reg;
            ack_q <= sd_ack;
        end
    end

    always_comb begin
        bk_ena_next = bk_ena_reg;
        if (dl_rise)
            bk_ena_next = 1'b0;
        else if (download && img_mounted && (img_size != 32'd0))
            bk_ena_next = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg   <= IDLE;
            index_reg   <= '0;
            slot_reg    <= '0;
            loading_reg <= 1'b0;
            dirty_reg   <= 1'b0;
            done_reg    <= 1'b0;
            bk_ena_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            slot_reg    <= slot_next;
            loading_reg <= loading_next;
            dirty_reg   <= dirty_next;
            done_reg    <= done_next;
            bk_ena_reg  <= bk_ena_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        slot_next    = slot_reg;
        loading_next = loading_reg;
        done_next    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (ld_trig || sv_trig) begin
                    slot_next    = slot;
                    loading_next = ld_trig;
                    index_next   = '0;
                    state_next   = REQ;
                end
            end
            REQ: begin
                if (ack_rise)
                    state_next = XFER;
            end
            XFER: begin
                if (ack_fall) begin
                    if (index_reg == '1) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        index_next = index_reg + SECT_BITS'(1);
                        state_next = REQ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // During a load the NVRAM writes come from user_io, so they don't count as
    // dirt; on a save's final sector a coincident core write must survive.
    always_comb begin
        dirty_next = dirty_reg;
        if (done_next)
            dirty_next = 1'b0;
        if (nvram_we && !(busy_int && loading_reg))
            dirty_next = 1'b1;
    end

    always_comb begin
        sd_lba = '0;
        sd_lba[LBA_BITS-1:0] = {slot_reg, index_reg};
    end

    assign sd_rd   = (state_reg == REQ) &  loading_reg;
    assign sd_wr   = (state_reg == REQ) & ~loading_reg;
    assign busy    = busy_int;
    assign loading = busy_int & loading_reg;
    assign bk_ena  = bk_ena_reg;
    assign dirty   = dirty_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Self-checking bench for nvram_backup_ctrl: drives the sd_ack handshake
// and compares against expected sector addresses, bk_ena and dirty state.
module tb_nvram_backup_ctrl;

    logic        clk_sys = 1'b0;
    logic        RESET_n;
    logic        download, img_mounted, bk_load, bk_save, nvram_we, sd_ack;
    logic [31:0] img_size;
    logic [1:0]  slot;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_ena, busy, loading, dirty, done;

    int total = 0;
    int bad   = 0;

    // Reference state derived from the behavioural rules
    bit exp_bk_ena = 1'b0;
    bit exp_dirty  = 1'b0;

    always #5 clk_sys = ~clk_sys;

    nvram_backup_ctrl #(.SECT_BITS(6), .SLOT_BITS(2)) dut (
        .clk_sys     (clk_sys),
        .RESET_n     (RESET_n),
        .download    (download),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .bk_load     (bk_load),
        .bk_save     (bk_save),
        .slot        (slot),
        .nvram_we    (nvram_we),
        .sd_ack      (sd_ack),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .bk_ena      (bk_ena),
        .busy        (busy),
        .loading     (loading),
        .dirty       (dirty),
        .done        (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_req"}, 32'(sd_rd | sd_wr), 32'd0);
        check_val({tag, "_loading"}, 32'(loading), 32'd0);
        check_val({tag, "_dirty"}, 32'(dirty), 32'(exp_dirty));
        check_val({tag, "_bk_ena"}, 32'(bk_ena), 32'(exp_bk_ena));
    endtask

    task automatic arm();
        download = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b1;
        img_size    = 32'd32768;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        download    = 1'b0;
        exp_bk_ena  = 1'b1;
        @(negedge clk_sys);
        check_val("arm_bk_ena", 32'(bk_ena), 32'd1);
    endtask

    // Plays the user_io side for one operation. Called at the negedge where the
    // first request must already be visible. abort_at >= 0 resets mid-transfer.
    task automatic run_op(input bit is_load, input int slot_v, input int rise_dly, input int hold,
                          input int abort_at, input bit we_last, input bit we_rand, input bit poke_load);
        int n_done = 0;
        int n_sect = 0;
        for (int i = 0; i < 64; i++) begin
            check_val("req_rd", 32'(sd_rd), 32'(is_load));
            check_val("req_wr", 32'(sd_wr), 32'(!is_load));
            check_val("lba", sd_lba, 32'(slot_v * 64 + i));
            check_val("busy_op", 32'(busy), 32'd1);
            check_val("loading_op", 32'(loading), 32'(is_load));
            check_val("dirty_op", 32'(dirty), 32'(exp_dirty));
            check_val("done_early", 32'(done), 32'd0);
            if (i == abort_at) begin
                RESET_n = 1'b0;
                #1;
                check_val("abort_req", 32'(sd_rd | sd_wr), 32'd0);
                check_val("abort_busy", 32'(busy), 32'd0);
                exp_bk_ena = 1'b0;
                exp_dirty  = 1'b0;
                repeat (3) begin
                    @(negedge clk_sys);
                    check_val("abort_done", 32'(done), 32'd0);
                    check_idle("abort_hold");
                end
                RESET_n = 1'b1;
                $display("op %s slot=%0d aborted at sector %0d", is_load ? "load" : "save", slot_v, i);
                return;
            end
            repeat (rise_dly) @(negedge clk_sys);
            check_val("req_hold", 32'(sd_rd | sd_wr), 32'd1);
            check_val("lba_stable", sd_lba, 32'(slot_v * 64 + i));
            sd_ack = 1'b1;
            @(negedge clk_sys);
            check_val("req_drop", 32'(sd_rd | sd_wr), 32'd0);
            if (poke_load && i == 5) bk_load = 1'b1;
            for (int h = 1; h < hold; h++) begin
                nvram_we = we_rand && ($urandom_range(0, 3) == 0);
                if (nvram_we && !is_load) exp_dirty = 1'b1;
                @(negedge clk_sys);
            end
            check_val("lba_xfer", sd_lba, 32'(slot_v * 64 + i));
            nvram_we = (i == 63) && we_last;
            sd_ack   = 1'b0;
            @(negedge clk_sys);
            nvram_we = 1'b0;
            n_sect++;
            if (done) n_done++;
            if (i == 63) exp_dirty = is_load ? 1'b0 : we_last;
        end
        check_val("sectors", 32'(n_sect), 32'd64);
        check_val("done_cnt", 32'(n_done), 32'd1);
        check_val("done_final", 32'(done), 32'd1);
        check_idle("end");
        @(negedge clk_sys);
        check_val("done_pulse", 32'(done), 32'd0);
        $display("op %s slot=%0d sectors=%0d done=%0d dirty=%0d",
                 is_load ? "load" : "save", slot_v, n_sect, n_done, dirty);
    endtask

    initial begin
        RESET_n = 1'b0;
        download = 1'b0; img_mounted = 1'b0; img_size = 32'd0;
        bk_load = 1'b0; bk_save = 1'b0; slot = 2'd0; nvram_we = 1'b0; sd_ack = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_val("rst_lba", sd_lba, 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_idle("rst");
        RESET_n = 1'b1;
        @(negedge clk_sys);
        check_idle("post_rst");

        // Disabled trigger
        bk_save = 1'b1;
        repeat (4) @(negedge clk_sys);
        check_idle("disabled");
        bk_save = 1'b0;

        // Dirty from a core write in IDLE
        nvram_we = 1'b1;
        @(negedge clk_sys);
        nvram_we = 1'b0;
        exp_dirty = 1'b1;
        check_val("dirty_idle", 32'(dirty), 32'd1);

        // Arming rules
        arm();
        $display("arm bk_ena=%0d", bk_ena);
        download = 1'b1;
        @(negedge clk_sys);
        exp_bk_ena = 1'b0;
        check_val("dl_rise_clear", 32'(bk_ena), 32'd0);
        img_mounted = 1'b1; img_size = 32'd0;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        check_val("size_zero", 32'(bk_ena), 32'd0);
        download = 1'b0;
        @(negedge clk_sys);
        download = 1'b1; img_mounted = 1'b1; img_size = 32'd32768;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        check_val("clear_wins", 32'(bk_ena), 32'd0);
        download = 1'b0;
        @(negedge clk_sys);
        $display("arm size0/coincide bk_ena=%0d", bk_ena);
        arm();

        // Full save on slot 2 with a load poke mid-transfer
        slot = 2'd2; bk_save = 1'b1;
        @(negedge clk_sys);
        slot = 2'd0;
        run_op(1'b0, 2, 3, 5, -1, 1'b0, 1'b1, 1'b1);
        bk_save = 1'b0; bk_load = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_idle("after_poke");

        // Simultaneous triggers: load wins, core writes ignored
        slot = 2'd1; bk_load = 1'b1; bk_save = 1'b1;
        @(negedge clk_sys);
        run_op(1'b1, 1, 2, 4, -1, 1'b1, 1'b1, 1'b0);
        bk_load = 1'b0; bk_save = 1'b0;
        @(negedge clk_sys);

        // Save whose final done coincides with a core write
        slot = 2'd3; bk_save = 1'b1;
        @(negedge clk_sys);
        run_op(1'b0, 3, 2, 3, -1, 1'b1, 1'b0, 1'b0);
        bk_save = 1'b0;
        @(negedge clk_sys);
        check_val("dirty_coincide", 32'(dirty), 32'd1);

        // Reset at sector 17, then a new save from index 0
        slot = 2'd1; bk_save = 1'b1;
        @(negedge clk_sys);
        run_op(1'b0, 1, 3, 5, 17, 1'b0, 1'b0, 1'b0);
        bk_save = 1'b0;
        @(negedge clk_sys);
        check_idle("post_abort");
        arm();
        slot = 2'd3; bk_save = 1'b1;
        @(negedge clk_sys);
        run_op(1'b0, 3, 3, 5, -1, 1'b0, 1'b0, 1'b0);
        bk_save = 1'b0;
        @(negedge clk_sys);

        // Randomized operations
        for (int k = 0; k < 4; k++) begin
            bit ld;
            int sl;
            ld = 1'($urandom_range(0, 1));
            sl = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                nvram_we = 1'b1;
                @(negedge clk_sys);
                nvram_we = 1'b0;
                exp_dirty = 1'b1;
                check_val("rnd_dirty_idle", 32'(dirty), 32'd1);
            end
            slot = 2'(sl);
            if (ld) bk_load = 1'b1; else bk_save = 1'b1;
            @(negedge clk_sys);
            run_op(ld, sl, int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), -1,
                   1'($urandom_range(0, 1)), 1'b1, 1'b0);
            bk_load = 1'b0; bk_save = 1'b0;
            @(negedge clk_sys);
            check_idle("rnd_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nvram_backup_ctrl.md
# nvram_backup_ctrl

Sequences battery-backup (NVRAM) save and load as a burst of SD-card sector transfers through the user_io sector interface (sd_lba / sd_rd / sd_wr / sd_ack). It sits between the OSD status bits and user_io, next to the dual-port NVRAM whose B port user_io streams sector data into and out of. The block also arms itself only after a save image is mounted during ROM download, and tracks whether NVRAM has changed since the last save.

## Interface
Parameters:
- SECT_BITS, 6 — log2 of sectors per save (64 × 512 B = 32 KiB NVRAM).
- SLOT_BITS, 2 — save-slot select width.

Ports:
- clk_sys  in  1  system clock; single clock domain.
- RESET_n  in  1  asynchronous, active-low reset.
- download  in  1  ROM download in progress (ioctl_download level).
- img_mounted  in  1  one-cycle pulse from user_io when an image is mounted.
- img_size  in  32  size of the mounted image in bytes.
- bk_load  in  1  load request, level; rising edge triggers.
- bk_save  in  1  save request, level; rising edge triggers.
- slot  in  SLOT_BITS  save slot; sampled at start of an operation.
- nvram_we  in  1  core-side NVRAM write strobe; sets the dirty flag.
- sd_ack  in  1  user_io sector acknowledge.
- sd_lba  out  32  sector address.
- sd_rd  out  1  sector read request.
- sd_wr  out  1  sector write request.
- bk_ena  out  1  backup image available.
- busy  out  1  operation in progress.
- loading  out  1  current operation is a load.
- dirty  out  1  NVRAM modified since last completed save or load.
- done  out  1  one-cycle pulse when the final sector completes.

## Operation
- Reset values: sd_lba = 0, sd_rd = 0, sd_wr = 0, bk_ena = 0, busy = 0, loading = 0, dirty = 0, done = 0, state IDLE. Reset mid-transfer aborts immediately with no completion pulse.
- bk_ena: cleared on the rising edge of download. Set while download = 1 if img_mounted = 1 and img_size ≠ 0. Clear wins if both occur in the same cycle.
- Edge detect: registers ld_q / sv_q hold bk_load & bk_ena and bk_save & bk_ena. A trigger fires when the input is high and its register is low.
- States:
  - IDLE: on trigger, latch slot and direction, set sector index = 0, go to REQ. If load and save trigger in the same cycle, load wins. Triggers are ignored when bk_ena = 0.
  - REQ: sd_rd = loading, sd_wr = ~loading. Wait for the sd_ack rise, then go to XFER.
  - XFER: wait for the sd_ack fall. If index = all ones: go to IDLE and pulse done. Otherwise increment index, go to REQ.
- sd_lba = zero-extended {slot_latched, index}, width SLOT_BITS+SECT_BITS.
- Triggers arriving while busy are dropped, not queued.
- dirty:
  - Set by nvram_we in any state, except while a load is busy; those writes come from user_io, not the core.
  - Cleared on done (save or load).
  - If nvram_we and done coincide, dirty ends at 1 for a save and 0 for a load.
- busy = (state ≠ IDLE). loading holds the latched direction while busy and is 0 in IDLE.

## Timing
- ack_q is sd_ack registered. Rise = sd_ack & ~ack_q; fall = ~sd_ack & ack_q.
- Trigger sampled at edge n → busy = 1, sd_rd or sd_wr = 1, and sd_lba valid at edge n+1.
- sd_rd/sd_wr drop on the first edge at which sd_ack is sampled high.
- On a fall: the next sector's sd_lba and request are asserted on that same edge, giving zero idle cycles between sectors. For the last sector, done = 1 and busy = 0 on that edge.
- sd_lba is stable from request assertion until the following ack fall.
- An sd_ack fall while in REQ, with no prior rise, is ignored.

## Structure
- Shared package (sms_pkg): SD_SECTOR_BYTES = 512 and the state enum {IDLE, REQ, XFER}.
- No sub-module. The edge detectors are inline registers; a single FSM plus index counter is the natural shape.

## Test plan
- Arming: download rise, img_mounted with img_size = 32768 → bk_ena = 1. A second download rise → bk_ena = 0. img_mounted with img_size = 0 → bk_ena stays 0.
- Full save, slot = 2: bk_save rise, ack model with 3-cycle rise delay and 5-cycle hold → 64 sd_wr requests at lba 128..191, zero-gap re-request, exactly one done pulse on the last ack fall, dirty cleared.
- Disabled and busy triggers: bk_save with bk_ena = 0 → no request. bk_load mid-save → ignored; the save still completes all 64 sectors.
- Simultaneous triggers: bk_load and bk_save rise in the same cycle → sd_rd only, loading = 1. nvram_we pulses during the load leave dirty = 0 after done.
- Reset mid-op: assert RESET_n = 0 at sector 17 → sd_rd/sd_wr/busy drop asynchronously and stay 0, no done. After release, a new save starts at index 0.
- Dirty tracking: nvram_we in IDLE → dirty = 1. nvram_we on the same cycle as the final save done → dirty = 1.
